rn4871_config_ctrl: RTL
=======================

Name: rn4871_config_ctrl

Overview:
- Power-up sequencer and TX/RX arbiter for the RN4871 Bluetooth PMOD.
- After reset, pulses the module reset, waits for boot, then sends a fixed command script over the byte-level UART TX. Each command must be acknowledged on the UART RX before the next one is sent.
- Once configured, hands the TX/RX byte paths to the user datapath (e.g. computer UART bridge, 7-segment display).
- Sits between UART_TX/UART_RX instances and the user logic.

Parameters:
- RESET_CLKS, 25000: clocks io_PMOD_8 (RST_N) is held low (1 ms at 25 MHz).
- BOOT_CLKS, 2500000: clocks to wait after RST_N release before the first command (100 ms).
- RESP_TIMEOUT_CLKS, 12500000: max clocks to wait for a command acknowledge (500 ms).
- MAX_RETRIES, 3: full-sequence restarts allowed before declaring error.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset
- o_BT_RST_N  out  1  RN4871 reset, active low
- o_TX_DV  out  1  one-cycle strobe to UART_TX
- o_TX_Byte  out  8  byte to UART_TX
- i_TX_Active  in  1  UART_TX busy
- i_TX_Done  in  1  UART_TX one-cycle done pulse
- i_RX_DV  in  1  UART_RX byte valid
- i_RX_Byte  in  8  UART_RX byte
- i_User_TX_DV  in  1  user byte request
- i_User_TX_Byte  in  8  user byte
- o_User_TX_Ready  out  1  user may strobe i_User_TX_DV
- o_User_RX_DV  out  1  forwarded RX strobe
- o_User_RX_Byte  out  8  forwarded RX byte
- o_Ready  out  1  configuration complete
- o_Error  out  1  retries exhausted
- o_Retry_Count  out  2  restarts so far

Behaviour:
- Interface: single clock i_Clk; i_Rst is synchronous, active-high. All outputs are registered.
- Reset values:
  - o_BT_RST_N=0
  - o_TX_DV=0, o_TX_Byte=0x00
  - o_User_TX_Ready=0, o_User_RX_DV=0, o_User_RX_Byte=0x00
  - o_Ready=0, o_Error=0, o_Retry_Count=0
  - FSM enters RST_ASSERT with its counter cleared.
- Reset taken at any time, mid-byte or mid-wait, restarts from RST_ASSERT. An in-flight UART_TX byte completes on the line but its i_TX_Done is ignored.
- Command script ROM (step, bytes, acknowledge char):
  - step 0: "$$$" (0x24 x3), expect '>' (0x3E)
  - step 1: "SS,C0\r", expect '>'
  - step 2: "---\r", expect 'D' (0x44, last char of "END")
- States:
  - RST_ASSERT: o_BT_RST_N=0 for RESET_CLKS clocks -> BOOT_WAIT.
  - BOOT_WAIT: o_BT_RST_N=1, count BOOT_CLKS -> SEND, step=0, index=0.
  - SEND: if !i_TX_Active, pulse o_TX_DV one cycle with the ROM byte -> TX_WAIT.
  - TX_WAIT: on i_TX_Done, if last byte of step -> RESP_WAIT with timer cleared; else index+1 -> SEND.
  - RESP_WAIT:
    - i_RX_DV with i_RX_Byte == ack char -> next step (SEND), or READY after step 2.
    - Non-matching bytes are ignored.
    - Timer reaching RESP_TIMEOUT_CLKS: if o_Retry_Count < MAX_RETRIES, increment it and go to RST_ASSERT; else go to ERROR.
    - Ack arriving on the exact cycle the timer expires counts as success.
  - READY: o_Ready=1, sticky until i_Rst.
  - ERROR: o_Error=1, o_BT_RST_N=1, no TX. Sticky until i_Rst.
- RX bytes received in SEND/TX_WAIT are discarded.
- In READY (arbitration):
  - o_User_TX_Ready = !i_TX_Active && !o_TX_DV.
  - i_User_TX_DV while ready -> o_TX_DV/o_TX_Byte next cycle (1-cycle latency).
  - i_User_TX_DV while not ready is dropped, with no queueing.
  - i_RX_DV/i_RX_Byte are forwarded to o_User_RX_DV/o_User_RX_Byte with 1-cycle latency.
- Outside READY: o_User_TX_Ready=0 and o_User_RX_DV=0 (see optional feature).
- Counters size to $clog2 of their parameter +1 and never wrap; each is cleared on state entry.

Optional Feature:
- Macro BT_CFG_RX_ECHO_EN.
- Defined: during RESP_WAIT, every received byte, matching or not, is also forwarded to o_User_RX_DV/o_User_RX_Byte (1-cycle latency), so the module's responses can be echoed to the computer for debug. This does not alter FSM behaviour.
- Undefined: configuration-phase RX is never forwarded.

Test Plan:
- Use RESET_CLKS=4, BOOT_CLKS=8, RESP_TIMEOUT_CLKS=50, MAX_RETRIES=2 with a UART_TX model that gives i_TX_Done 10 cycles after o_TX_DV.
- Nominal:
  - Stimulus: release i_Rst; model replies '>', '>', 'D' 5 cycles after each command's last Done.
  - Response: o_BT_RST_N low exactly 4 cycles, first o_TX_DV 8 cycles after release, TX bytes 24 24 24 53 53 2C 43 30 0D 2D 2D 2D 0D, o_Ready=1, o_Retry_Count=0.
- Noise:
  - Stimulus: during step 0 RESP_WAIT, send 'C','M','D',' ' then '>'.
  - Response: only '>' advances; step 1 begins on the next cycle.
- Timeout:
  - Stimulus: no reply to "$$$".
  - Response: after 50 clocks o_Retry_Count=1 and o_BT_RST_N drops for 4 cycles; after 3 total timeouts o_Error=1, o_Ready=0, no further o_TX_DV.
- User path:
  - Stimulus: in READY, strobe i_User_TX_DV=0x41, then strobe again while i_TX_Active=1; inject i_RX_DV=0x5A.
  - Response: o_TX_DV/0x41 one cycle later; second strobe dropped; o_User_RX_DV/0x5A one cycle later.
- Mid-run reset:
  - Stimulus: assert i_Rst during TX_WAIT of step 1.
  - Response: all outputs return to reset values next cycle; the sequence restarts at "$$$".
- Echo (BT_CFG_RX_ECHO_EN defined):
  - Stimulus: 'C' in RESP_WAIT.
  - Response: o_User_RX_DV=1, o_User_RX_Byte=0x43. With the macro undefined, o_User_RX_DV stays 0.

Source files
------------

// File: rtl/rn4871_config_ctrl.sv
// rn4871_config_ctrl
// Power-up sequencer and TX/RX arbiter for the RN4871 Bluetooth PMOD.
// Pulses the module reset, waits for boot, plays a fixed command script over
// the byte-level UART TX, and checks each command's acknowledge on the UART RX.
// Once configured, the TX/RX byte paths belong to the user datapath.
// Optional build macro: BT_CFG_RX_ECHO_EN, which also forwards every byte received
// while waiting for an acknowledge to the user RX port for debug.
module rn4871_config_ctrl #(
  parameter int RESET_CLKS        = 25000,
  parameter int BOOT_CLKS         = 2500000,
  parameter int RESP_TIMEOUT_CLKS = 12500000,
  parameter int MAX_RETRIES       = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_BT_RST_N,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_User_TX_DV,
  input  logic [7:0] i_User_TX_Byte,
  output logic       o_User_TX_Ready,
  output logic       o_User_RX_DV,
  output logic [7:0] o_User_RX_Byte,
  output logic       o_Ready,
  output logic       o_Error,
  output logic [1:0] o_Retry_Count
);

  localparam int CNT_MAX =
    (RESET_CLKS > BOOT_CLKS)
      ? ((RESET_CLKS > RESP_TIMEOUT_CLKS) ? RESET_CLKS : RESP_TIMEOUT_CLKS)
      : ((BOOT_CLKS > RESP_TIMEOUT_CLKS) ? BOOT_CLKS : RESP_TIMEOUT_CLKS);
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CLKS - 1);
  // The SEND cycle counts as the last boot clock, so the first command strobe
  // lands exactly BOOT_CLKS clocks after the module reset is released.
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_CLKS > 1) ? BOOT_CLKS - 2 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RESP_TIMEOUT_CLKS - 1);
  localparam logic [1:0]       MAX_R     = 2'(MAX_RETRIES);

  localparam logic [2:0] S_RST_ASSERT = 3'd0;
  localparam logic [2:0] S_BOOT_WAIT  = 3'd1;
  localparam logic [2:0] S_SEND       = 3'd2;
  localparam logic [2:0] S_TX_WAIT    = 3'd3;
  localparam logic [2:0] S_RESP_WAIT  = 3'd4;
  localparam logic [2:0] S_READY      = 3'd5;
  localparam logic [2:0] S_ERROR      = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       retry_q, retry_d;
  logic             bt_rst_n_q, bt_rst_n_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             user_tx_ready_q, user_tx_ready_d;
  logic             user_rx_dv_q, user_rx_dv_d;
  logic [7:0]       user_rx_byte_q, user_rx_byte_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  // Script bytes: "$$$", "SS,C0\r", "---\r".
  function automatic logic [7:0] rom_byte(input logic [1:0] step, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (step)
      2'd0: b = 8'h24;
      2'd1: begin
        case (idx)
          3'd0, 3'd1: b = 8'h53;
          3'd2:       b = 8'h2C;
          3'd3:       b = 8'h43;
          3'd4:       b = 8'h30;
          default:    b = 8'h0D;
        endcase
      end
      2'd2: b = (idx < 3'd3) ? 8'h2D : 8'h0D;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] rom_last(input logic [1:0] step);
    logic [2:0] l;
    case (step)
      2'd0:    l = 3'd2;
      2'd1:    l = 3'd5;
      2'd2:    l = 3'd3;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  // Step 2 is acknowledged by the 'D' that ends "END"; the others by the prompt.
  function automatic logic [7:0] ack_char(input logic [1:0] step);
    return (step == 2'd2) ? 8'h44 : 8'h3E;
  endfunction

  // Next-state logic for the sequencer, the counters and every registered output.
  always_comb begin
    state_d         = state_q;
    cnt_d           = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    step_d          = step_q;
    idx_d           = idx_q;
    retry_d         = retry_q;
    bt_rst_n_d      = bt_rst_n_q;
    tx_dv_d         = 1'b0;
    tx_byte_d       = tx_byte_q;
    user_tx_ready_d = 1'b0;
    user_rx_dv_d    = 1'b0;
    user_rx_byte_d  = user_rx_byte_q;
    ready_d         = ready_q;
    error_d         = error_q;

    case (state_q)
      S_RST_ASSERT: begin
        bt_rst_n_d = 1'b0;
        if (cnt_q == RST_LAST) begin
          state_d    = S_BOOT_WAIT;
          cnt_d      = '0;
          bt_rst_n_d = 1'b1;
        end
      end
      S_BOOT_WAIT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = S_SEND;
          cnt_d   = '0;
          step_d  = 2'd0;
          idx_d   = 3'd0;
        end
      end
      S_SEND: begin
        if (!i_TX_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = rom_byte(step_q, idx_q);
          state_d   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (i_TX_Done) begin
          if (idx_q == rom_last(step_q)) begin
            state_d = S_RESP_WAIT;
            cnt_d   = '0;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end
        end
      end
      S_RESP_WAIT: begin
`ifdef BT_CFG_RX_ECHO_EN
        user_rx_dv_d = i_RX_DV;
        if (i_RX_DV) user_rx_byte_d = i_RX_Byte;
`else
        user_rx_dv_d = 1'b0;
`endif
        // An acknowledge beats a timeout that expires on the same cycle.
        if (i_RX_DV && (i_RX_Byte == ack_char(step_q))) begin
          if (step_q == 2'd2) begin
            state_d = S_READY;
            ready_d = 1'b1;
          end else begin
            step_d  = step_q + 2'd1;
            idx_d   = 3'd0;
            state_d = S_SEND;
          end
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < MAX_R) begin
            retry_d    = retry_q + 2'd1;
            state_d    = S_RST_ASSERT;
            cnt_d      = '0;
            bt_rst_n_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_READY: begin
        user_rx_dv_d = i_RX_DV;
        if (i_RX_DV) user_rx_byte_d = i_RX_Byte;
        if (i_User_TX_DV && user_tx_ready_q && !i_TX_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = i_User_TX_Byte;
        end
        user_tx_ready_d = !i_TX_Active && !tx_dv_d;
      end
      S_ERROR: begin
        bt_rst_n_d = 1'b1;
      end
      default: begin
        state_d = S_RST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset back to RST_ASSERT.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q         <= S_RST_ASSERT;
      cnt_q           <= '0;
      step_q          <= 2'd0;
      idx_q           <= 3'd0;
      retry_q         <= 2'd0;
      bt_rst_n_q      <= 1'b0;
      tx_dv_q         <= 1'b0;
      tx_byte_q       <= 8'h00;
      user_tx_ready_q <= 1'b0;
      user_rx_dv_q    <= 1'b0;
      user_rx_byte_q  <= 8'h00;
      ready_q         <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      step_q          <= step_d;
      idx_q           <= idx_d;
      retry_q         <= retry_d;
      bt_rst_n_q      <= bt_rst_n_d;
      tx_dv_q         <= tx_dv_d;
      tx_byte_q       <= tx_byte_d;
      user_tx_ready_q <= user_tx_ready_d;
      user_rx_dv_q    <= user_rx_dv_d;
      user_rx_byte_q  <= user_rx_byte_d;
      ready_q         <= ready_d;
      error_q         <= error_d;
    end
  end

  assign o_BT_RST_N      = bt_rst_n_q;
  assign o_TX_DV         = tx_dv_q;
  assign o_TX_Byte       = tx_byte_q;
  assign o_User_TX_Ready = user_tx_ready_q;
  assign o_User_RX_DV    = user_rx_dv_q;
  assign o_User_RX_Byte  = user_rx_byte_q;
  assign o_Ready         = ready_q;
  assign o_Error         = error_q;
  assign o_Retry_Count   = retry_q;

endmodule
